lbp_sequencer: RTL and testbench

LBP_SEQUENCER -- requirements
Module: lbp_sequencer

---
 rtl/lbp_pkg.sv | 36 +++
 rtl/lbp_wb_regs.sv | 139 +++++++++++++
 rtl/lbp_sequencer.sv | 216 +++++++++++++++++++++
 tb/tb_lbp_sequencer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lbp_pkg.sv
// Shared types and constants for the LBP photodiode sequencer.
// FSM states, register offsets and control/status bit positions.
package lbp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RST     = 3'd1,
    ST_SAMPLE  = 3'd2,
    ST_GAP     = 3'd3,
    ST_SELECT  = 3'd4,
    ST_STROBE  = 3'd5,
    ST_CAPTURE = 3'd6,
    ST_DONE    = 3'd7
  } state_t;

  localparam logic [3:0] OFF_CTRL   = 4'h0;
  localparam logic [3:0] OFF_CFG    = 4'h4;
  localparam logic [3:0] OFF_STATUS = 4'h8;
  localparam logic [3:0] OFF_RESULT = 4'hC;

  localparam int CTRL_START  = 0;
  localparam int CTRL_CONT   = 1;
  localparam int CTRL_IRQ_EN = 2;
  localparam int CTRL_ABORT  = 3;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_OVR  = 2;

  function automatic logic [7:0] at_least_one(
    input logic [7:0] v
  );
    return (v == 8'd0) ? 8'd1 : v;
  endfunction

endpackage

// File: rtl/lbp_wb_regs.sv
// Wishbone slave register file for the LBP sequencer.
// Holds CTRL/CFG/STATUS/RESULT and emits start/abort pulses.
module lbp_wb_regs
  import lbp_pkg::*;
#(
  parameter int          N_PD     = 12,
  parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wbs_cyc_i,
  input  logic            wbs_stb_i,
  input  logic            wbs_we_i,
  input  logic [3:0]      wbs_sel_i,
  input  logic [31:0]     wbs_adr_i,
  input  logic [31:0]     wbs_dat_i,
  output logic [31:0]     wbs_dat_o,
  output logic            wbs_ack_o,
  input  logic            busy,
  input  logic            frame_done,
  input  logic [N_PD-1:0] pattern,
  output logic            start,
  output logic            abort,
  output logic            continuous,
  output logic [7:0]      cfg_s,
  output logic [7:0]      cfg_h,
  output logic [4:0]      cfg_c,
  output logic            irq
);

  logic            hit;
  logic            req;
  logic            served;
  logic            acc;
  logic            wr;
  logic [3:0]      off;
  logic            wr_ctrl;
  logic            wr_cfg;
  logic            wr_stat;
  logic            clr_done;
  logic            clr_ovr;
  logic            irq_en;
  logic            done;
  logic            ovr;
  logic [N_PD-1:0] result;
  logic [31:0]     rdata;
  logic            unused;

  assign hit     = wbs_adr_i[31:4] == BASE_ADR[31:4];
  assign req     = wbs_cyc_i & wbs_stb_i & hit;
  assign acc     = req & ~served;
  assign wr      = acc & wbs_we_i;
  assign off     = wbs_adr_i[3:0];
  assign wr_ctrl = wr & (off == OFF_CTRL);
  assign wr_cfg  = wr & (off == OFF_CFG);
  assign wr_stat = wr & (off == OFF_STATUS);
  assign clr_done = wr_stat & wbs_sel_i[0]
                  & wbs_dat_i[STAT_DONE];
  assign clr_ovr  = wr_stat & wbs_sel_i[0]
                  & wbs_dat_i[STAT_OVR];
  assign irq     = done & irq_en;
  assign unused  = ^wbs_dat_i[31:21];

  // read mux; unaligned offsets read as zero
  always_comb begin
    rdata = '0;
    case (off)
      OFF_CTRL: begin
        rdata[CTRL_CONT]   = continuous;
        rdata[CTRL_IRQ_EN] = irq_en;
      end
      OFF_CFG:    rdata = {11'd0, cfg_c, cfg_h, cfg_s};
      OFF_STATUS: begin
        rdata[STAT_BUSY] = busy;
        rdata[STAT_DONE] = done;
        rdata[STAT_OVR]  = ovr;
      end
      OFF_RESULT: rdata = 32'(result);
      default:    rdata = '0;
    endcase
  end

  // handshake: one ack per strobe burst, registered read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      served    <= 1'b0;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      served    <= req;
      wbs_ack_o <= acc;
      if (acc && !wbs_we_i) wbs_dat_o <= rdata;
    end
  end

  // control and config registers, start/abort self-clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start      <= 1'b0;
      abort      <= 1'b0;
      continuous <= 1'b0;
      irq_en     <= 1'b0;
      cfg_s      <= '0;
      cfg_h      <= '0;
      cfg_c      <= '0;
    end else begin
      start <= 1'b0;
      abort <= 1'b0;
      if (wr_ctrl && wbs_sel_i[0]) begin
        start      <= wbs_dat_i[CTRL_START];
        abort      <= wbs_dat_i[CTRL_ABORT];
        continuous <= wbs_dat_i[CTRL_CONT];
        irq_en     <= wbs_dat_i[CTRL_IRQ_EN];
      end
      if (wr_cfg && wbs_sel_i[0]) cfg_s <= wbs_dat_i[7:0];
      if (wr_cfg && wbs_sel_i[1]) cfg_h <= wbs_dat_i[15:8];
      if (wr_cfg && wbs_sel_i[2]) cfg_c <= wbs_dat_i[20:16];
    end
  end

  // status and result; frame completion beats a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done   <= 1'b0;
      ovr    <= 1'b0;
      result <= '0;
    end else begin
      if (frame_done) begin
        done   <= 1'b1;
        result <= pattern;
      end else if (clr_done) begin
        done <= 1'b0;
      end
      if (frame_done && done) ovr <= 1'b1;
      else if (clr_ovr)       ovr <= 1'b0;
    end
  end

endmodule

// File: rtl/lbp_sequencer.sv
// LBP photodiode sequencer: resets the pixel, samples the centre,
// then compares each channel against it to build a binary pattern.
module lbp_sequencer
  import lbp_pkg::*;
#(
  parameter int          N_PD     = 12,
  parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_n,
  input  logic            wbs_cyc_i,
  input  logic            wbs_stb_i,
  input  logic            wbs_we_i,
  input  logic [3:0]      wbs_sel_i,
  input  logic [31:0]     wbs_adr_i,
  input  logic [31:0]     wbs_dat_i,
  output logic [31:0]     wbs_dat_o,
  output logic            wbs_ack_o,
  input  logic            cmp_i,
  output logic [N_PD-1:0] pd_a_o,
  output logic [N_PD-1:0] pd_b_o,
  output logic            sh_rst_o,
  output logic            sh_o,
  output logic            sh_cmp_o,
  output logic            irq_o
);

  state_t          state, state_d;
  logic [7:0]      cnt, cnt_d;
  logic [7:0]      s_len, s_len_d;
  logic [7:0]      h_len, h_len_d;
  logic [4:0]      ctr, ctr_d;
  logic [4:0]      idx, idx_d;
  logic [N_PD-1:0] pat, pat_d;
  logic [N_PD-1:0] pd_a_d, pd_b_d;
  logic            sh_rst_d, sh_d, sh_cmp_d;
  logic            cmp_s1, cmp_s2;
  logic            start, abort, continuous;
  logic [7:0]      cfg_s, cfg_h;
  logic [4:0]      cfg_c;
  logic [7:0]      s_eff, h_eff;
  logic [4:0]      c_eff;
  logic            busy, frame_done;

  assign busy       = state != ST_IDLE;
  assign frame_done = state == ST_DONE;
  assign s_eff      = at_least_one(cfg_s);
  assign h_eff      = at_least_one(cfg_h);
  assign c_eff      = (int'(cfg_c) >= N_PD) ? 5'd0 : cfg_c;

  function automatic logic [N_PD-1:0] onehot(
    input logic [4:0] k
  );
    return {{(N_PD-1){1'b0}}, 1'b1} << k;
  endfunction

  lbp_wb_regs #(
    .N_PD     (N_PD),
    .BASE_ADR (BASE_ADR)
  ) u_regs (
    .clk        (wb_clk_i),
    .rst_n      (wb_rst_n),
    .wbs_cyc_i  (wbs_cyc_i),
    .wbs_stb_i  (wbs_stb_i),
    .wbs_we_i   (wbs_we_i),
    .wbs_sel_i  (wbs_sel_i),
    .wbs_adr_i  (wbs_adr_i),
    .wbs_dat_i  (wbs_dat_i),
    .wbs_dat_o  (wbs_dat_o),
    .wbs_ack_o  (wbs_ack_o),
    .busy       (busy),
    .frame_done (frame_done),
    .pattern    (pat),
    .start      (start),
    .abort      (abort),
    .continuous (continuous),
    .cfg_s      (cfg_s),
    .cfg_h      (cfg_h),
    .cfg_c      (cfg_c),
    .irq        (irq_o)
  );

  // two-flop synchroniser for the asynchronous comparator
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      cmp_s1 <= 1'b0;
      cmp_s2 <= 1'b0;
    end else begin
      cmp_s1 <= cmp_i;
      cmp_s2 <= cmp_s1;
    end
  end

  // next state, counters and next-cycle analog controls
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    s_len_d = s_len;
    h_len_d = h_len;
    ctr_d   = ctr;
    idx_d   = idx;
    pat_d   = pat;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RST;
          s_len_d = s_eff;
          h_len_d = h_eff;
          ctr_d   = c_eff;
          cnt_d   = s_eff - 8'd1;
        end
      end
      ST_RST: begin
        if (cnt == 8'd0) begin
          state_d = ST_SAMPLE;
          cnt_d   = h_len - 8'd1;
        end else begin
          cnt_d = cnt - 8'd1;
        end
      end
      ST_SAMPLE: begin
        if (cnt == 8'd0) begin
          state_d = ST_GAP;
          idx_d   = 5'd0;
        end else begin
          cnt_d = cnt - 8'd1;
        end
      end
      ST_GAP: begin
        state_d = ST_SELECT;
        cnt_d   = s_len - 8'd1;
      end
      ST_SELECT: begin
        if (cnt == 8'd0) state_d = ST_STROBE;
        else             cnt_d   = cnt - 8'd1;
      end
      ST_STROBE: begin
        state_d = ST_CAPTURE;
        cnt_d   = 8'd1;
      end
      ST_CAPTURE: begin
        if (cnt == 8'd0) begin
          pat_d = (pat & ~onehot(idx))
                | (cmp_s2 ? onehot(idx) : '0);
          if (idx == 5'(N_PD - 1)) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx + 5'd1;
            state_d = ST_GAP;
          end
        end else begin
          cnt_d = cnt - 8'd1;
        end
      end
      ST_DONE: begin
        if (continuous) begin
          state_d = ST_RST;
          s_len_d = s_eff;
          h_len_d = h_eff;
          ctr_d   = c_eff;
          cnt_d   = s_eff - 8'd1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;

    sh_rst_d = state_d == ST_RST;
    sh_d     = state_d == ST_SAMPLE;
    sh_cmp_d = state_d == ST_STROBE;
    pd_b_d   = sh_d ? onehot(ctr_d) : '0;
    pd_a_d   = (state_d == ST_SELECT || sh_cmp_d)
             ? onehot(idx_d) : '0;
  end

  // state and datapath registers
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      s_len <= '0;
      h_len <= '0;
      ctr   <= '0;
      idx   <= '0;
      pat   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      s_len <= s_len_d;
      h_len <= h_len_d;
      ctr   <= ctr_d;
      idx   <= idx_d;
      pat   <= pat_d;
    end
  end

  // registered analog controls, glitch-free and aligned with state
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      pd_a_o   <= '0;
      pd_b_o   <= '0;
      sh_rst_o <= 1'b0;
      sh_o     <= 1'b0;
      sh_cmp_o <= 1'b0;
    end else begin
      pd_a_o   <= pd_a_d;
      pd_b_o   <= pd_b_d;
      sh_rst_o <= sh_rst_d;
      sh_o     <= sh_d;
      sh_cmp_o <= sh_cmp_d;
    end
  end

endmodule

// File: tb/tb_lbp_sequencer.sv
// Directed bench for lbp_sequencer.
// Frame timing, pattern capture, status flags, abort and reset.
module tb_lbp_sequencer;

  localparam int          N    = 12;
  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [31:0] A_CTRL = BASE + 32'h0;
  localparam logic [31:0] A_CFG  = BASE + 32'h4;
  localparam logic [31:0] A_STAT = BASE + 32'h8;
  localparam logic [31:0] A_RES  = BASE + 32'hC;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]    sel = 4'h0;
  logic [31:0]   adr = '0, wdat = '0;
  logic [31:0]   rdat;
  logic          ack;
  logic          cmp_i;
  logic [N-1:0]  pd_a_o, pd_b_o;
  logic          sh_rst_o, sh_o, sh_cmp_o, irq_o;
  logic [N-1:0]  cmp_mask = '0;

  int total = 0;
  int bad = 0;
  int n_rise = 0, n_shrst = 0, n_sh = 0, n_cmp = 0, len = 0;
  logic [N-1:0] seen_a = '0, seen_b = '0;
  logic [N-1:0] prev_pd = '0, prev_a = '0;
  logic         prev_shrst = 1'b0;
  logic [31:0]  r;

  always #5 clk = ~clk;

  // comparator model: high when a masked channel is routed
  always_comb cmp_i = |(pd_a_o & cmp_mask);

  lbp_sequencer #(.N_PD(N), .BASE_ADR(BASE)) dut (
    .wb_clk_i  (clk),
    .wb_rst_n  (rst_n),
    .wbs_cyc_i (cyc),
    .wbs_stb_i (stb),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (wdat),
    .wbs_dat_o (rdat),
    .wbs_ack_o (ack),
    .cmp_i     (cmp_i),
    .pd_a_o    (pd_a_o),
    .pd_b_o    (pd_b_o),
    .sh_rst_o  (sh_rst_o),
    .sh_o      (sh_o),
    .sh_cmp_o  (sh_cmp_o),
    .irq_o     (irq_o)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("onehot",
          32'($countones(pd_a_o | pd_b_o) <= 1), 32'd1);
      if (pd_a_o != '0 && prev_a == '0)
        chk("bbm", 32'(prev_pd), 32'd0);
      if (sh_rst_o && !prev_shrst) n_rise++;
      if (n_rise > 0 && !irq_o) len++;
      n_shrst += int'(sh_rst_o);
      n_sh    += int'(sh_o);
      n_cmp   += int'(sh_cmp_o);
      seen_a  |= pd_a_o;
      seen_b  |= pd_b_o;
    end
    prev_pd    = pd_a_o | pd_b_o;
    prev_a     = pd_a_o;
    prev_shrst = sh_rst_o;
  end

  task automatic clr_mon();
    @(posedge clk);
    n_rise = 0; n_shrst = 0; n_sh = 0; n_cmp = 0; len = 0;
    seen_a = '0; seen_b = '0;
  endtask

  task automatic wb(input logic [31:0] a, input logic w,
                    input logic [31:0] d, input logic [3:0] s,
                    output logic [31:0] rd);
    bit got = 0;
    rd = '0;
    @(negedge clk);
    cyc = 1; stb = 1; we = w; adr = a; wdat = d; sel = s;
    for (int i = 0; i < 4 && !got; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (ack) begin
        got = 1;
        rd = rdat;
      end
    end
    cyc = 0; stb = 0; we = 0;
    chk("ack", 32'(got), 32'd1);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] x;
    wb(a, 1'b1, d, 4'hF, x);
  endtask

  task automatic rdchk(input string tag, input logic [31:0] a,
                       input logic [31:0] exp);
    logic [31:0] x;
    wb(a, 1'b0, '0, 4'hF, x);
    chk(tag, x, exp);
  endtask

  task automatic wait_irq(input int maxc);
    for (int i = 0; i < maxc && !irq_o; i++) @(negedge clk);
    chk("irq_wait", 32'(irq_o), 32'd1);
  endtask

  initial begin
    int nack;
    int first;
    // reset state
    #3;
    chk("rst_pd", 32'(pd_a_o | pd_b_o), 32'd0);
    chk("rst_sh", {29'd0, sh_rst_o, sh_o, sh_cmp_o}, 32'd0);
    chk("rst_ack_irq", {30'd0, ack, irq_o}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rdchk("rst_ctrl", A_CTRL, 32'd0);
    rdchk("rst_stat", A_STAT, 32'd0);
    rdchk("rst_res", A_RES, 32'd0);

    // strobe held three cycles gives one ack
    @(negedge clk);
    cyc = 1; stb = 1; we = 0; adr = A_STAT;
    nack = 0; first = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      nack += int'(ack);
      if (i == 0) first = int'(ack);
    end
    cyc = 0; stb = 0;
    chk("hold_first", 32'(first), 32'd1);
    chk("hold_nack", 32'(nack), 32'd1);
    @(negedge clk);
    chk("hold_after", 32'(ack), 32'd0);

    // out-of-window address never acks
    cyc = 1; stb = 1; adr = BASE + 32'h10;
    nack = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      nack += int'(ack);
    end
    cyc = 0; stb = 0;
    chk("oow_nack", 32'(nack), 32'd0);

    // byte lanes
    wb(A_CFG, 1'b1, 32'hFFFF_FFFF, 4'b0010, r);
    rdchk("sel_h", A_CFG, 32'h0000_FF00);
    wb(A_CFG, 1'b1, 32'hFFFF_FFFF, 4'b0100, r);
    rdchk("sel_c", A_CFG, 32'h001F_FF00);
    rdchk("unaligned", BASE + 32'h5, 32'd0);

    // nominal frame: S=2 H=3 C=5, odd channels high
    wr(A_CFG, 32'h0005_0302);
    rdchk("cfg", A_CFG, 32'h0005_0302);
    cmp_mask = 12'hAAA;
    clr_mon();
    wr(A_CTRL, 32'h5);
    rdchk("busy", A_STAT, 32'h1);
    wr(A_CTRL, 32'h5);
    wait_irq(200);
    chk("len78", 32'(len), 32'd78);
    chk("n_shrst", 32'(n_shrst), 32'd2);
    chk("n_sh", 32'(n_sh), 32'd3);
    chk("n_cmp", 32'(n_cmp), 32'd12);
    chk("seen_a", 32'(seen_a), 32'hFFF);
    chk("seen_b", 32'(seen_b), 32'h020);
    rdchk("res_aaa", A_RES, 32'h0000_0AAA);
    rdchk("stat_done", A_STAT, 32'h2);
    wr(A_STAT, 32'h2);
    rdchk("stat_clr", A_STAT, 32'h0);
    chk("irq_clr", 32'(irq_o), 32'd0);

    // continuous: overrun after second frame
    cmp_mask = 12'h0F0;
    clr_mon();
    wr(A_CTRL, 32'h3);
    for (int i = 0; i < 400 && n_rise < 3; i++) @(negedge clk);
    chk("cont_rise", 32'(n_rise), 32'd3);
    rdchk("cont_stat", A_STAT, 32'h7);
    rdchk("cont_res", A_RES, 32'h0000_00F0);
    wr(A_CTRL, 32'h0);
    repeat (120) @(negedge clk);
    rdchk("cont_end", A_STAT, 32'h6);
    chk("cont_nrise", 32'(n_rise), 32'd3);
    wr(A_STAT, 32'h6);
    rdchk("w1c_both", A_STAT, 32'h0);

    // abort during SELECT of channel 4
    wr(A_CFG, 32'h0005_0314);
    cmp_mask = 12'hFFF;
    clr_mon();
    wr(A_CTRL, 32'h1);
    for (int i = 0; i < 800 && pd_a_o != 12'h010; i++)
      @(negedge clk);
    chk("ab_sel4", 32'(pd_a_o), 32'h010);
    wr(A_CTRL, 32'h8);
    @(negedge clk);
    chk("ab_pd", 32'(pd_a_o | pd_b_o), 32'd0);
    chk("ab_sh", {29'd0, sh_rst_o, sh_o, sh_cmp_o}, 32'd0);
    repeat (40) @(negedge clk);
    chk("ab_nrise", 32'(n_rise), 32'd1);
    rdchk("ab_stat", A_STAT, 32'h0);
    rdchk("ab_res", A_RES, 32'h0000_00F0);

    // reset pulse during STROBE
    wr(A_CFG, 32'h0005_0302);
    cmp_mask = 12'hAAA;
    wr(A_CTRL, 32'h1);
    for (int i = 0; i < 200 && !sh_cmp_o; i++) @(negedge clk);
    chk("rs_strobe", 32'(sh_cmp_o), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rs_cmp", 32'(sh_cmp_o), 32'd0);
    chk("rs_pd", 32'(pd_a_o | pd_b_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    clr_mon();
    rdchk("rs_ctrl", A_CTRL, 32'd0);
    rdchk("rs_cfg", A_CFG, 32'd0);
    rdchk("rs_stat", A_STAT, 32'd0);
    rdchk("rs_res", A_RES, 32'd0);
    repeat (20) @(negedge clk);
    chk("rs_quiet", 32'(n_rise + n_cmp + n_sh), 32'd0);

    // CFG=0 behaves as S=H=1, C=0
    wr(A_CFG, 32'h0);
    cmp_mask = 12'h001;
    clr_mon();
    wr(A_CTRL, 32'h5);
    wait_irq(200);
    chk("len63", 32'(len), 32'd63);
    chk("z_shrst", 32'(n_shrst), 32'd1);
    chk("z_sh", 32'(n_sh), 32'd1);
    chk("z_cmp", 32'(n_cmp), 32'd12);
    chk("z_seen_b", 32'(seen_b), 32'h001);
    rdchk("z_res", A_RES, 32'h0000_0001);

    // centre index out of range falls back to 0
    wr(A_STAT, 32'h2);
    wr(A_CFG, 32'h0014_0000);
    cmp_mask = 12'h800;
    clr_mon();
    wr(A_CTRL, 32'h5);
    wait_irq(200);
    chk("c20_seen_b", 32'(seen_b), 32'h001);
    rdchk("c20_res", A_RES, 32'h0000_0800);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
